memory_arbiter: RTL

Two-port arbiter that shares the single data-side memory interface between the instruction fetch path and the load/store path. It sits between the core (fetch unit and LSU) and the memory interface. It serializes one transaction at a time and latches all request fields. It handles the enable/done handshake toward memory and returns read data plus a one-cycle done pulse to whichever requester was granted.

---
 rtl/memory_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares one data-side memory interface between the instruction fetch path
//   and the load/store path. One transaction is in flight at a time, and all
//   request fields are latched at grant. A done pulse and registered read data
//   are returned to the granted requester. bus_error qualifies a done pulse
//   whose transaction timed out.
//
//   Build option: ARBITER_ROUND_ROBIN_EN
//     defined   -> round-robin on a tie; the last-grant register resets to LSU,
//                  so fetch wins the first tie
//     undefined -> fixed priority; LSU wins every tie
//
//   Ports
//     CLK, reset       clock; synchronous active-high reset
//     fetch_*          fetch read request (req/address in, data/done out)
//     lsu_*            load/store request (req/write/mask/address/store data in,
//                      load data/done out)
//     bus_error        high with a done pulse when the transaction timed out
//     mem_*            memory side: enable/write/mask/address/write data out,
//                      read data/done in
//
//   state   | meaning
//   IDLE    | no transaction; arbitrate on the pending requests
//   BUSY    | mem_* held stable, waiting for mem_done or the timeout
//   RELEASE | done pulse cycle; requests ignored while requesters drop req
module memory_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_address,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_done,
  input  logic                  lsu_req,
  input  logic                  lsu_write,
  input  logic [3:0]            lsu_frame_mask,
  input  logic [ADDR_WIDTH-1:0] lsu_address,
  input  logic [DATA_WIDTH-1:0] lsu_store_data,
  output logic [DATA_WIDTH-1:0] lsu_load_data,
  output logic                  lsu_done,
  output logic                  bus_error,
  output logic                  mem_enable,
  output logic                  mem_write,
  output logic [3:0]            mem_frame_mask,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  mem_done
);

  // The timer counts completed BUSY cycles; hitting TIMEOUT_CYCLES-1 while in
  // BUSY means this is the last allowed cycle.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]         TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK  = ~(ADDR_WIDTH'(3));

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t                state, state_nxt;
  logic                  grant_lsu, grant_lsu_nxt;
  logic [TW-1:0]         timer, timer_nxt;
  logic                  pick_lsu;
  logic [ADDR_WIDTH-1:0] sel_address;

  logic                  mem_enable_nxt, mem_write_nxt;
  logic [3:0]            mem_frame_mask_nxt;
  logic [ADDR_WIDTH-1:0] mem_address_nxt;
  logic [DATA_WIDTH-1:0] mem_write_data_nxt;
  logic [DATA_WIDTH-1:0] fetch_data_nxt, lsu_load_data_nxt;
  logic                  fetch_done_nxt, lsu_done_nxt, bus_error_nxt;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic last_lsu, last_lsu_nxt;

  // On a tie the port that was not granted last wins.
  assign pick_lsu     = lsu_req & (~fetch_req | ~last_lsu);
  assign last_lsu_nxt = ((state == IDLE) && (fetch_req || lsu_req)) ? pick_lsu : last_lsu;

  always_ff @(posedge CLK) begin
    if (reset) last_lsu <= 1'b1;
    else       last_lsu <= last_lsu_nxt;
  end
`else
  assign pick_lsu = lsu_req;
`endif

  assign sel_address = pick_lsu ? lsu_address : fetch_address;

  always_comb begin
    state_nxt          = state;
    grant_lsu_nxt      = grant_lsu;
    timer_nxt          = timer;
    mem_enable_nxt     = mem_enable;
    mem_write_nxt      = mem_write;
    mem_frame_mask_nxt = mem_frame_mask;
    mem_address_nxt    = mem_address;
    mem_write_data_nxt = mem_write_data;
    fetch_data_nxt     = fetch_data;
    lsu_load_data_nxt  = lsu_load_data;
    fetch_done_nxt     = 1'b0;
    lsu_done_nxt       = 1'b0;
    bus_error_nxt      = 1'b0;

    case (state)
      IDLE: begin
        if (fetch_req || lsu_req) begin
          grant_lsu_nxt      = pick_lsu;
          mem_enable_nxt     = 1'b1;
          mem_write_nxt      = pick_lsu & lsu_write;
          mem_frame_mask_nxt = pick_lsu ? lsu_frame_mask : 4'b1111;
          mem_address_nxt    = sel_address & WORD_MASK;
          mem_write_data_nxt = pick_lsu ? lsu_store_data : '0;
          timer_nxt          = '0;
          state_nxt          = BUSY;
        end
      end
      BUSY: begin
        // mem_done takes precedence over a timeout in the same cycle.
        if (mem_done || (timer == TIMER_LAST)) begin
          if (mem_done && !mem_write) begin
            if (grant_lsu) lsu_load_data_nxt = mem_read_data;
            else           fetch_data_nxt    = mem_read_data;
          end
          lsu_done_nxt       = grant_lsu;
          fetch_done_nxt     = ~grant_lsu;
          bus_error_nxt      = ~mem_done;
          mem_enable_nxt     = 1'b0;
          mem_write_nxt      = 1'b0;
          mem_frame_mask_nxt = '0;
          mem_address_nxt    = '0;
          mem_write_data_nxt = '0;
          state_nxt          = RELEASE;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state          <= IDLE;
      grant_lsu      <= 1'b0;
      timer          <= '0;
      mem_enable     <= 1'b0;
      mem_write      <= 1'b0;
      mem_frame_mask <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      fetch_data     <= '0;
      lsu_load_data  <= '0;
      fetch_done     <= 1'b0;
      lsu_done       <= 1'b0;
      bus_error      <= 1'b0;
    end else begin
      state          <= state_nxt;
      grant_lsu      <= grant_lsu_nxt;
      timer          <= timer_nxt;
      mem_enable     <= mem_enable_nxt;
      mem_write      <= mem_write_nxt;
      mem_frame_mask <= mem_frame_mask_nxt;
      mem_address    <= mem_address_nxt;
      mem_write_data <= mem_write_data_nxt;
      fetch_data     <= fetch_data_nxt;
      lsu_load_data  <= lsu_load_data_nxt;
      fetch_done     <= fetch_done_nxt;
      lsu_done       <= lsu_done_nxt;
      bus_error      <= bus_error_nxt;
    end
  end

endmodule
